// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane widths.
// The misalignment helper is only consulted when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_MERGE_WR = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Size 2'b11 behaves like a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational byte-lane logic: extracts/extends load lanes and merges store lanes
// into a memory word, little-endian (byte k = bits [8k+7:8k]).
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [4:0]          byteBase;
    logic [BYTE_W-1:0]   selByte;
    logic [HALF_W-1:0]   selHalf;

    always_comb begin
        byteBase     = {offset_i, 3'b000};
        selByte      = word_i[byteBase +: BYTE_W];
        selHalf      = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o  = word_i;
        merge_data_o = word_i;
        case (size_i)
            SIZE_B: begin
                load_data_o = {{(WORD_W-BYTE_W){~unsigned_i & selByte[BYTE_W-1]}}, selByte};
                merge_data_o[byteBase +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            SIZE_H: begin
                load_data_o = {{(WORD_W-HALF_W){~unsigned_i & selHalf[HALF_W-1]}}, selHalf};
                if (offset_i[1]) merge_data_o[31:16] = wdata_i[HALF_W-1:0];
                else             merge_data_o[15:0]  = wdata_i[HALF_W-1:0];
            end
            default: begin
                load_data_o  = word_i;
                merge_data_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for the word-wide data_memory; sub-word stores
// use a read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 257
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;
    logic        fault_q, fault_d;
    logic [31:0] laneLoad, laneMerge;
    logic        wordStore;

    lsu_lane_mux u_lane_mux (
        .word_i       (mem_read_data),
        .offset_i     (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .load_data_o  (laneLoad),
        .merge_data_o (laneMerge)
    );

    assign wordStore = we_q & size_q[1];

    // Response data and fault are cleared at accept so stores and traps report zero data.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    fault_d = 1'b0;
                    state_d = ST_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (!we_q) begin
                    rdata_d = laneLoad;
                end else if (!size_q[1]) begin
                    merge_d = laneMerge;
                    state_d = ST_MERGE_WR;
                end
            end
            ST_MERGE_WR: state_d = ST_RESP;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= SIZE_B;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            fault_q <= fault_d;
        end
    end

    // Memory strobes depend on state alone, so an async reset kills a write instantly.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                mem_address = {2'b00, addr_q[31:2]};
                if (wordStore) begin
                    mem_write      = 1'b1;
                    mem_write_data = wdata_q;
                end
            end
            ST_MERGE_WR: begin
                mem_address    = {2'b00, addr_q[31:2]};
                mem_write      = 1'b1;
                mem_write_data = merge_q;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data_memory model.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:256];
    logic        memInit = 1'b1;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expFault;
        int          expLat;
        int          expWrCycle;
        logic [31:0] expWrAddr;
        logic [31:0] expWrData;
    } vec_t;

    vec_t vecs [0:13];

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [31:0] W8_FINAL = 32'hDEADBEEF;
`else
    localparam logic [31:0] W8_FINAL = 32'hDEAD5555;
`endif

    load_store_unit #(.MEM_WORDS(257)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_address < 32'd257) ? mem[mem_address[8:0]] : 32'h0;

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 257; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (mem_write && mem_address < 32'd257) begin
            mem[mem_address[8:0]] <= mem_write_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int          rspCycle = 0;
        int          wrCycle  = 0;
        int          wrCount  = 0;
        logic [31:0] wrAddr   = '0;
        logic [31:0] wrData   = '0;
        logic [31:0] rdata    = '0;
        logic        fault    = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8 && rspCycle == 0; k++) begin
            @(negedge clk);
            if (mem_write) begin
                wrCount++;
                if (wrCycle == 0) begin
                    wrCycle = k;
                    wrAddr  = mem_address;
                    wrData  = mem_write_data;
                end
            end
            if (rsp_valid) begin
                rspCycle = k;
                rdata    = rsp_rdata;
                fault    = rsp_fault;
            end
        end
        checkOutput($sformatf("v%0d rsp latency", idx), rspCycle, v.expLat);
        checkOutput($sformatf("v%0d rdata", idx), rdata, v.expRdata);
        checkOutput($sformatf("v%0d fault", idx), {31'b0, fault}, {31'b0, v.expFault});
        checkOutput($sformatf("v%0d write cycle", idx), wrCycle, v.expWrCycle);
        checkOutput($sformatf("v%0d write count", idx), wrCount, (v.expWrCycle != 0) ? 1 : 0);
        if (v.expWrCycle != 0) begin
            checkOutput($sformatf("v%0d write addr", idx), wrAddr, v.expWrAddr);
            checkOutput($sformatf("v%0d write data", idx), wrData, v.expWrData);
        end
    endtask

    initial begin
        logic [31:0] b2bAddr [0:2];
        logic [1:0]  b2bSize [0:2];
        logic        b2bUns  [0:2];
        logic [31:0] b2bExp  [0:2];
        int          accCycle [0:2];
        int          accIdx, rspIdx;

        //            we    size   uns   addr          wdata          rdata         flt  lat wrC wrAddr  wrData
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 32'h0,  32'h0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2, 0, 32'h0,  32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,  32'h0};
`else
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'h8899AABB, 1'b0, 2, 0, 32'h0,  32'h0};
`endif
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0,        1'b0, 3, 2, 32'h4,  32'h1234AABB};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1234AABB, 1'b0, 2, 0, 32'h0,  32'h0};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'h8,  32'hDEADBEEF};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 32'h0,  32'h0};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h0000DEAD, 1'b0, 2, 0, 32'h0,  32'h0};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h20, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, 32'h0,  32'h0};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h43, 32'hFFFFFF7F, 32'h0,        1'b0, 3, 2, 32'h10, 32'h7F000000};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h43, 32'h0,        32'h0000007F, 1'b0, 2, 0, 32'h0,  32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h21, 32'h00005555, 32'h0,        1'b1, 1, 0, 32'h0,  32'h0};
`else
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h21, 32'h00005555, 32'h0,        1'b0, 3, 2, 32'h8,  32'hDEAD5555};
`endif
        vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        W8_FINAL,     1'b0, 2, 0, 32'h0,  32'h0};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h00000034, 1'b0, 2, 0, 32'h0,  32'h0};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 memInit = 1'b0;
        @(negedge clk);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset rsp_fault", {31'b0, rsp_fault}, 32'd0);
        checkOutput("reset mem_write", {31'b0, mem_write}, 32'd0);
        checkOutput("reset mem_address", mem_address, 32'd0);
        checkOutput("reset mem_write_data", mem_write_data, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

        // Reset while the merged word is being written must leave word 4 intact.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rmw access no write", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        checkOutput("rmw merge write", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1 checkOutput("reset drops write", {31'b0, mem_write}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("word4 after reset", mem[4], 32'h1234AABB);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post reset ready", {31'b0, req_ready}, 32'd1);
        checkOutput("post reset rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Three loads with req_valid held high.
        b2bAddr[0] = 32'h10; b2bSize[0] = 2'b00; b2bUns[0] = 1'b0; b2bExp[0] = 32'hFFFFFFBB;
        b2bAddr[1] = 32'h12; b2bSize[1] = 2'b01; b2bUns[1] = 1'b1; b2bExp[1] = 32'h00001234;
        b2bAddr[2] = 32'h20; b2bSize[2] = 2'b10; b2bUns[2] = 1'b0; b2bExp[2] = W8_FINAL;
        accIdx = 0; rspIdx = 0;
        req_valid = 1'b1; req_we = 1'b0;
        req_addr = b2bAddr[0]; req_size = b2bSize[0]; req_unsigned = b2bUns[0];
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (rsp_valid) begin
                if (rspIdx < 3) begin
                    checkOutput($sformatf("b2b rsp%0d data", rspIdx), rsp_rdata, b2bExp[rspIdx]);
                    checkOutput($sformatf("b2b rsp%0d cycle", rspIdx), cyc, accCycle[rspIdx] + 2);
                end
                rspIdx++;
            end
            if (req_ready && req_valid) begin
                accCycle[accIdx] = cyc;
                if (accIdx > 0)
                    checkOutput($sformatf("b2b accept%0d spacing", accIdx), cyc - accCycle[accIdx-1], 32'd3);
                accIdx++;
                @(posedge clk);
                #1;
                if (accIdx < 3) begin
                    req_addr = b2bAddr[accIdx]; req_size = b2bSize[accIdx]; req_unsigned = b2bUns[accIdx];
                end else begin
                    req_valid = 1'b0;
                end
            end else if (req_ready && !req_valid) begin
                @(posedge clk);
            end else begin
                @(posedge clk);
            end
        end
        checkOutput("b2b accept count", accIdx, 32'd3);
        checkOutput("b2b response count", rspIdx, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
